// File: rtl/ltssm_substate_sequencer.sv
// LTSSM top: walks Detect/Polling/Config/L0/Recovery one at a time and muxes the active TX stream to m_axis.
// en_o/state registered one cycle after the outcome; m_axis is a combinational mux, tready passed only to the selected source.
module ltssm_substate_sequencer #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int          USER_WIDTH     = 8,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'hDACA,
  parameter int          MAX_RETRY      = 8,
  localparam int         NS             = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic                     force_detect_i,
  output logic [NS-1:0]            en_o,
  input  logic [NS-1:0]            success_i,
  input  logic [NS-1:0]            error_i,
  output logic [2:0]               ltssm_state_o,
  output logic                     link_up_o,
  output logic [7:0]               retry_cnt_o,
  output logic                     fail_o,
  input  logic [NS*DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [NS*KEEP_WIDTH-1:0] s_axis_tkeep_i,
  input  logic [NS*USER_WIDTH-1:0] s_axis_tuser_i,
  input  logic [NS-1:0]            s_axis_tvalid_i,
  input  logic [NS-1:0]            s_axis_tlast_i,
  output logic [NS-1:0]            s_axis_tready_o,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata_o,
  output logic [KEEP_WIDTH-1:0]    m_axis_tkeep_o,
  output logic                     m_axis_tvalid_o,
  output logic                     m_axis_tlast_o,
  output logic [USER_WIDTH-1:0]    m_axis_tuser_o,
  input  logic                     m_axis_tready_i
);

  typedef enum logic [1:0] {PH_IDLE, PH_RUN, PH_DRAIN} phase_e;

  localparam logic [2:0] S_DET  = 3'd0;
  localparam logic [2:0] S_POL  = 3'd1;
  localparam logic [2:0] S_CFG  = 3'd2;
  localparam logic [2:0] S_L0   = 3'd3;
  localparam logic [2:0] S_REC  = 3'd4;
  localparam logic [2:0] S_NONE = 3'd7;

  phase_e      phase;
  logic [2:0]  sel;
  logic [2:0]  target;
  logic [31:0] timer;

  logic        cur_succ;
  logic        cur_err;
  logic        cur_tvalid;
  logic        timed_out;
  logic        run_done;
  logic        run_inc;
  logic [2:0]  run_target;
  logic [7:0]  retry_next;
  logic        retry_fail;
  logic [2:0]  drain_target;
  logic        drain_exit;

  function automatic logic [NS-1:0] onehot(input logic [2:0] s);
    logic [NS-1:0] v;
    v = '0;
    for (int i = 0; i < NS; i++) begin
      if (s == 3'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Selected-source view and the TX mux; sel=7 selects nothing.
  always_comb begin
    cur_succ        = 1'b0;
    cur_err         = 1'b0;
    cur_tvalid      = 1'b0;
    m_axis_tdata_o  = '0;
    m_axis_tkeep_o  = '0;
    m_axis_tuser_o  = '0;
    m_axis_tvalid_o = 1'b0;
    m_axis_tlast_o  = 1'b0;
    s_axis_tready_o = '0;
    for (int i = 0; i < NS; i++) begin
      if (sel == 3'(i)) begin
        cur_succ           = success_i[i];
        cur_err            = error_i[i];
        cur_tvalid         = s_axis_tvalid_i[i];
        m_axis_tdata_o     = s_axis_tdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep_o     = s_axis_tkeep_i[i*KEEP_WIDTH +: KEEP_WIDTH];
        m_axis_tuser_o     = s_axis_tuser_i[i*USER_WIDTH +: USER_WIDTH];
        m_axis_tvalid_o    = s_axis_tvalid_i[i];
        m_axis_tlast_o     = s_axis_tlast_i[i];
        s_axis_tready_o[i] = m_axis_tready_i;
      end
    end
  end

  assign timed_out  = (timer >= TIMEOUT_CYCLES);
  assign retry_next = (retry_cnt_o == 8'hFF) ? 8'hFF : retry_cnt_o + 8'd1;
  assign retry_fail = run_inc && (int'(retry_next) >= MAX_RETRY);

  // Link-down request beats everything; error beats success; L0 never times out.
  always_comb begin
    run_done   = 1'b0;
    run_inc    = 1'b0;
    run_target = S_DET;
    if (force_detect_i) begin
      run_done = 1'b1;
    end else if (sel == S_L0) begin
      if (cur_err) begin
        run_done   = 1'b1;
        run_target = S_REC;
      end
    end else if (cur_err || timed_out) begin
      run_done = 1'b1;
      run_inc  = 1'b1;
    end else if (cur_succ) begin
      run_done   = 1'b1;
      run_target = (sel == S_REC) ? S_L0 : sel + 3'd1;
    end
  end

  assign drain_target = force_detect_i ? S_DET : target;
  // Holding sel until the source is quiet keeps a pending beat on the same path.
  assign drain_exit   = (!cur_succ && !cur_err && !cur_tvalid) || timed_out;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase         <= PH_IDLE;
      sel           <= S_NONE;
      target        <= S_DET;
      timer         <= '0;
      en_o          <= '0;
      link_up_o     <= 1'b0;
      ltssm_state_o <= S_NONE;
      retry_cnt_o   <= '0;
      fail_o        <= 1'b0;
    end else if (!enable_i) begin
      phase         <= PH_IDLE;
      sel           <= S_NONE;
      target        <= S_DET;
      timer         <= '0;
      en_o          <= '0;
      link_up_o     <= 1'b0;
      ltssm_state_o <= S_NONE;
      retry_cnt_o   <= '0;
      fail_o        <= 1'b0;
    end else begin
      case (phase)
        PH_IDLE: begin
          if (!fail_o) begin
            phase         <= PH_RUN;
            sel           <= S_DET;
            en_o          <= onehot(S_DET);
            ltssm_state_o <= S_DET;
            link_up_o     <= 1'b0;
            timer         <= '0;
          end
        end
        PH_RUN: begin
          if (run_done) begin
            timer     <= '0;
            en_o      <= '0;
            link_up_o <= 1'b0;
            if (run_inc) retry_cnt_o <= retry_next;
            if (retry_fail) begin
              fail_o        <= 1'b1;
              phase         <= PH_IDLE;
              sel           <= S_NONE;
              ltssm_state_o <= S_NONE;
            end else begin
              phase  <= PH_DRAIN;
              target <= run_target;
            end
          end else if (!timed_out) begin
            timer <= timer + 32'd1;
          end
        end
        PH_DRAIN: begin
          if (drain_exit) begin
            phase         <= PH_RUN;
            sel           <= drain_target;
            en_o          <= onehot(drain_target);
            ltssm_state_o <= drain_target;
            link_up_o     <= (drain_target == S_L0);
            timer         <= '0;
            if (drain_target == S_L0) retry_cnt_o <= '0;
          end else begin
            timer <= timer + 32'd1;
            if (force_detect_i) target <= S_DET;
          end
        end
        default: begin
          phase         <= PH_IDLE;
          sel           <= S_NONE;
          en_o          <= '0;
          link_up_o     <= 1'b0;
          ltssm_state_o <= S_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ltssm_substate_sequencer.sv
// Directed bench for ltssm_substate_sequencer: walks happy path, recovery, drain hold, timeout, retry exhaustion and async reset.
module tb_ltssm_substate_sequencer;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         enable_i;
  logic         force_detect_i;
  logic [4:0]   en_o;
  logic [4:0]   success_i;
  logic [4:0]   error_i;
  logic [2:0]   ltssm_state_o;
  logic         link_up_o;
  logic [7:0]   retry_cnt_o;
  logic         fail_o;
  logic [159:0] s_axis_tdata_i;
  logic [19:0]  s_axis_tkeep_i;
  logic [39:0]  s_axis_tuser_i;
  logic [4:0]   s_axis_tvalid_i;
  logic [4:0]   s_axis_tlast_i;
  logic [4:0]   s_axis_tready_o;
  logic [31:0]  m_axis_tdata_o;
  logic [3:0]   m_axis_tkeep_o;
  logic         m_axis_tvalid_o;
  logic         m_axis_tlast_o;
  logic [7:0]   m_axis_tuser_o;
  logic         m_axis_tready_i;

  int checks = 0;
  int errors = 0;
  int beats0 = 0;

  always #5 clk_i = ~clk_i;

  ltssm_substate_sequencer #(
    .DATA_WIDTH(32), .USER_WIDTH(8), .TIMEOUT_CYCLES(32'd16), .MAX_RETRY(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .force_detect_i(force_detect_i),
    .en_o(en_o), .success_i(success_i), .error_i(error_i), .ltssm_state_o(ltssm_state_o),
    .link_up_o(link_up_o), .retry_cnt_o(retry_cnt_o), .fail_o(fail_o),
    .s_axis_tdata_i(s_axis_tdata_i), .s_axis_tkeep_i(s_axis_tkeep_i),
    .s_axis_tuser_i(s_axis_tuser_i), .s_axis_tvalid_i(s_axis_tvalid_i),
    .s_axis_tlast_i(s_axis_tlast_i), .s_axis_tready_o(s_axis_tready_o),
    .m_axis_tdata_o(m_axis_tdata_o), .m_axis_tkeep_o(m_axis_tkeep_o),
    .m_axis_tvalid_o(m_axis_tvalid_o), .m_axis_tlast_o(m_axis_tlast_o),
    .m_axis_tuser_o(m_axis_tuser_o), .m_axis_tready_i(m_axis_tready_i)
  );

  // Source-0 handshakes, sampled at the edge that consumes them.
  always @(posedge clk_i) begin
    if (s_axis_tvalid_i[0] && s_axis_tready_o[0]) beats0 <= beats0 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Substate s succeeds 3 cycles after its enable; one drain cycle, then nxt is enabled.
  task automatic run_success(input int s, input int nxt);
    tick(); tick(); tick();
    success_i[s] = 1'b1;
    tick();
    chk("drain_en_low", 32'(en_o), 32'h0);
    chk("drain_state", 32'(ltssm_state_o), 32'(s));
    success_i[s] = 1'b0;
    tick();
    chk("next_en", 32'(en_o), 32'(1 << nxt));
  endtask

  initial begin
    rst_ni          = 1'b0;
    enable_i        = 1'b0;
    force_detect_i  = 1'b0;
    success_i       = '0;
    error_i         = '0;
    s_axis_tvalid_i = '0;
    s_axis_tlast_i  = 5'b11111;
    s_axis_tkeep_i  = '1;
    m_axis_tready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_axis_tdata_i[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      s_axis_tuser_i[i*8 +: 8]   = 8'(8'h50 + i);
    end

    tick();
    chk("rst_en", 32'(en_o), 32'h0);
    chk("rst_state", 32'(ltssm_state_o), 32'h7);
    chk("rst_link", 32'(link_up_o), 32'h0);
    chk("rst_retry", 32'(retry_cnt_o), 32'h0);
    chk("rst_fail", 32'(fail_o), 32'h0);
    chk("rst_mvalid", 32'(m_axis_tvalid_o), 32'h0);
    rst_ni = 1'b1;
    tick();
    chk("idle_disabled_en", 32'(en_o), 32'h0);
    enable_i = 1'b1;
    tick();
    chk("det_en", 32'(en_o), 32'h01);
    chk("det_state", 32'(ltssm_state_o), 32'h0);

    // Happy path to L0
    run_success(0, 1);
    run_success(1, 2);
    run_success(2, 3);
    chk("l0_link", 32'(link_up_o), 32'h1);
    chk("l0_state", 32'(ltssm_state_o), 32'h3);
    chk("l0_retry", 32'(retry_cnt_o), 32'h0);

    // L0 -> Recovery -> L0
    error_i[3] = 1'b1;
    tick();
    chk("l0_err_en", 32'(en_o), 32'h0);
    chk("l0_err_link", 32'(link_up_o), 32'h0);
    error_i[3] = 1'b0;
    tick();
    chk("rec_en", 32'(en_o), 32'h10);
    chk("rec_state", 32'(ltssm_state_o), 32'h4);
    success_i[4] = 1'b1;
    tick();
    chk("rec_drain_en", 32'(en_o), 32'h0);
    success_i[4] = 1'b0;
    tick();
    chk("rec_l0_en", 32'(en_o), 32'h08);
    chk("rec_l0_link", 32'(link_up_o), 32'h1);

    // Link-down request from L0
    force_detect_i = 1'b1;
    tick();
    chk("force_en", 32'(en_o), 32'h0);
    force_detect_i = 1'b0;
    tick();
    chk("force_det_en", 32'(en_o), 32'h01);
    chk("force_retry", 32'(retry_cnt_o), 32'h0);

    // Drain hold: beat pending with downstream stalled
    tick(); tick(); tick();
    success_i[0]       = 1'b1;
    s_axis_tvalid_i[0] = 1'b1;
    tick();
    success_i[0] = 1'b0;
    chk("hold_en0", 32'(en_o), 32'h0);
    chk("hold_mvalid", 32'(m_axis_tvalid_o), 32'h1);
    chk("hold_mdata", m_axis_tdata_o, 32'hA000_0000);
    chk("hold_muser", 32'(m_axis_tuser_o), 32'h50);
    chk("hold_sready", 32'(s_axis_tready_o), 32'h0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold_en", 32'(en_o), 32'h0);
    end
    m_axis_tready_i = 1'b1;
    #1;
    chk("hold_sready_sel", 32'(s_axis_tready_o), 32'h01);
    tick();
    s_axis_tvalid_i[0] = 1'b0;
    m_axis_tready_i    = 1'b0;
    chk("hold_last_en", 32'(en_o), 32'h0);
    tick();
    chk("hold_pol_en", 32'(en_o), 32'h02);
    chk("hold_beats", 32'(beats0), 32'h1);

    // Polling timeout
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk("to_running", 32'(en_o), 32'h02);
    end
    tick();
    chk("to_drop", 32'(en_o), 32'h0);
    chk("to_state", 32'(ltssm_state_o), 32'h1);
    tick();
    chk("to_det_en", 32'(en_o), 32'h01);
    chk("to_retry", 32'(retry_cnt_o), 32'h1);

    // enable_i low aborts and clears retry
    enable_i = 1'b0;
    tick();
    chk("abort_en", 32'(en_o), 32'h0);
    chk("abort_state", 32'(ltssm_state_o), 32'h7);
    chk("abort_retry", 32'(retry_cnt_o), 32'h0);
    enable_i = 1'b1;
    tick();
    chk("restart_en", 32'(en_o), 32'h01);

    // Detect failures up to retry exhaustion
    for (int k = 1; k <= 8; k++) begin
      error_i[0] = 1'b1;
      tick();
      error_i[0] = 1'b0;
      chk("fail_retry", 32'(retry_cnt_o), 32'(k));
      chk("fail_en_low", 32'(en_o), 32'h0);
      if (k < 8) begin
        chk("fail_flag_low", 32'(fail_o), 32'h0);
        tick();
        chk("fail_det_en", 32'(en_o), 32'h01);
        if (k == 2) begin
          force_detect_i = 1'b1;
          tick();
          force_detect_i = 1'b0;
          chk("det_force_en", 32'(en_o), 32'h0);
          tick();
          chk("det_force_en1", 32'(en_o), 32'h01);
          chk("det_force_retry", 32'(retry_cnt_o), 32'h2);
        end
      end
    end
    chk("exhaust_fail", 32'(fail_o), 32'h1);
    chk("exhaust_state", 32'(ltssm_state_o), 32'h7);
    tick(); tick();
    chk("exhaust_stay_en", 32'(en_o), 32'h0);
    chk("exhaust_stay_fail", 32'(fail_o), 32'h1);
    enable_i = 1'b0;
    tick();
    chk("clr_fail", 32'(fail_o), 32'h0);
    chk("clr_retry", 32'(retry_cnt_o), 32'h0);
    enable_i = 1'b1;
    tick();
    chk("reenable_en", 32'(en_o), 32'h01);

    // Async reset in Config, away from any clock edge
    run_success(0, 1);
    run_success(1, 2);
    s_axis_tvalid_i[2] = 1'b1;
    #1;
    chk("cfg_mvalid", 32'(m_axis_tvalid_o), 32'h1);
    chk("cfg_mdata", m_axis_tdata_o, 32'hA000_0002);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("arst_en", 32'(en_o), 32'h0);
    chk("arst_state", 32'(ltssm_state_o), 32'h7);
    chk("arst_link", 32'(link_up_o), 32'h0);
    chk("arst_retry", 32'(retry_cnt_o), 32'h0);
    chk("arst_fail", 32'(fail_o), 32'h0);
    chk("arst_mvalid", 32'(m_axis_tvalid_o), 32'h0);
    chk("arst_sready", 32'(s_axis_tready_o), 32'h0);
    tick();
    rst_ni = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
